line_raster: RTL and testbench
==============================

// Module: line_raster
// PURPOSE
//  Parametrised Bresenham line rasteriser, next generation of the line-drawing engine.
//  Takes signed endpoints and a colour, then emits one framebuffer write per pixel,
//  stepping through the line one pixel per accepted write.
//  Over the previous generation it adds: generic coordinate, colour and screen sizes;
//  FB_ready backpressure; a busy flag; a pixel count; and optional screen clipping.
//  Sits between the command front-end and the framebuffer write port.
// PARAMETERS
//  WIDTH    13   signed coordinate width (x0..y1, internal x/y)
//  SCREEN_W 320  framebuffer width in pixels (row pitch)
//  SCREEN_H 240  framebuffer height in pixels
//  ADDR_W   17   framebuffer address width
//  COLOR_W  1    bits per colour channel
// PORTS
//  clk          in   1        clock, all logic on rising edge
//  reset        in   1        synchronous, active-high reset
//  start        in   1        pulse to begin a line; sampled only in IDLE
//  x0,y0,x1,y1  in   WIDTH    signed endpoints (two's complement)
//  red_in       in   COLOR_W  colour, latched on accepted start
//  green_in     in   COLOR_W  colour, latched on accepted start
//  blue_in      in   COLOR_W  colour, latched on accepted start
//  FB_ready     in   1        framebuffer accepts the write this cycle
//  FB_WE        out  1        write request
//  FB_addr      out  ADDR_W   y*SCREEN_W+x, truncated to ADDR_W
//  red_out      out  COLOR_W  latched colour
//  green_out    out  COLOR_W  latched colour
//  blue_out     out  COLOR_W  latched colour
//  busy         out  1        high from accepted start until sys_finish cycle inclusive
//  sys_finish   out  1        one-cycle pulse at end of line
//  pixel_count  out  ADDR_W+1 accepted writes for current/last line; cleared on start
// BEHAVIOUR
//  Reset: state=IDLE. FB_WE, busy, sys_finish, pixel_count, FB_addr and colour outputs all 0.
//  FSM IDLE->SETUP->DRAW->DONE->IDLE.
//   IDLE: start=1 latches endpoints and colour, clears pixel_count, goes to SETUP.
//   SETUP (1 cyc): computes, in WIDTH+2 signed:
//     dx=|x1-x0|, dy=-|y1-y0|, sx=(x0<x1)?+1:-1, sy=(y0<y1)?+1:-1,
//     err=dx+dy, x=x0, y=y0.
//   DRAW: FB_WE=1 and FB_addr=y*SCREEN_W+x (combinational from x,y regs).
//     On FB_WE&&FB_ready: pixel_count++.
//       If x==x1 && y==y1 -> DONE.
//       Else e2=2*err (WIDTH+3 bits); both tests use the old e2 and updates accumulate:
//         if e2>=dy: err+=dy, x+=sx.  if e2<=dx: err+=dx, y+=sy.
//     While FB_ready=0: x, y, err, FB_addr and FB_WE held stable.
//   DONE (1 cyc): sys_finish=1, busy=1, FB_WE=0, then IDLE.
//  Latency: start at cycle 0 -> first FB_WE at cycle 2.
//    With FB_ready tied high, N pixels -> sys_finish at cycle N+2.
//  start while busy: ignored, with no effect on the line in progress.
//  x0==x1 && y0==y1: exactly one write.
//  reset mid-line: IDLE next cycle, FB_WE=0, the line is abandoned.
//  Colour outputs hold their last value after the line completes.
// CONFIGURATION
//  LINE_CLIP_EN defined:
//    In DRAW, a pixel with x<0, x>=SCREEN_W, y<0 or y>=SCREEN_H gets FB_WE=0.
//    It is stepped over in one cycle (FB_ready ignored) and is not counted.
//  LINE_CLIP_EN undefined: no clipping, every pixel written.
//    Callers must supply on-screen endpoints; off-screen addresses are truncated to ADDR_W.
// TESTING
//  (0,0)->(3,0), FB_ready=1: FB_addr 0,1,2,3 on consecutive cycles;
//    sys_finish at cycle 6; pixel_count=4.
//  (0,0)->(2,4), SCREEN_W=320: FB_addr 0,321,641,962,1282; pixel_count=5.
//  (3,0)->(0,0): FB_addr 3,2,1,0. Also (5,5)->(5,5): single write at 1605, then sys_finish.
//  (0,0)->(3,0) with FB_ready low cycles 3-5: FB_addr held at 1, FB_WE held high;
//    sys_finish delayed 3 cycles; a start pulsed mid-line is ignored.
//  reset asserted during DRAW of (0,0)->(9,0): next cycle FB_WE=0, busy=0;
//    a new start then draws a full line.
//  LINE_CLIP_EN, (-2,0)->(1,0): only addrs 0,1 written; pixel_count=2;
//    sys_finish at cycle 6.

Source files
------------

// File: rtl/line_raster.sv
// ============================================================================
//  Module      : line_raster
//  Description : Parametrised Bresenham line rasteriser. Accepts two signed
//                endpoints and a colour, then issues one framebuffer write per
//                pixel, advancing one pixel per accepted write (FB_ready
//                backpressure). Reports busy, a one-cycle finish pulse and the
//                number of pixels written for the current/last line.
//  Config      : define LINE_CLIP_EN to suppress writes for off-screen pixels
//                (they are stepped over in one cycle and not counted).
//  Ports       : clk, reset (sync, active-high), start, x0/y0/x1/y1 (signed
//                endpoints), red_in/green_in/blue_in (colour), FB_ready (in);
//                FB_WE, FB_addr, red_out/green_out/blue_out, busy, sys_finish,
//                pixel_count (out).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module line_raster #(
  parameter int WIDTH    = 13,
  parameter int SCREEN_W = 320,
  parameter int SCREEN_H = 240,
  parameter int ADDR_W   = 17,
  parameter int COLOR_W  = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [WIDTH-1:0]   x0,
  input  logic [WIDTH-1:0]   y0,
  input  logic [WIDTH-1:0]   x1,
  input  logic [WIDTH-1:0]   y1,
  input  logic [COLOR_W-1:0] red_in,
  input  logic [COLOR_W-1:0] green_in,
  input  logic [COLOR_W-1:0] blue_in,
  input  logic               FB_ready,
  output logic               FB_WE,
  output logic [ADDR_W-1:0]  FB_addr,
  output logic [COLOR_W-1:0] red_out,
  output logic [COLOR_W-1:0] green_out,
  output logic [COLOR_W-1:0] blue_out,
  output logic               busy,
  output logic               sys_finish,
  output logic [ADDR_W:0]    pixel_count
);

  // Internal coordinate / error width and the doubled-error width.
  localparam int CW = WIDTH + 2;
  localparam int EW = WIDTH + 3;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SETUP = 2'd1,
    S_DRAW  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t state, state_next;

  // Latched endpoints
  logic signed [WIDTH-1:0] lx0, ly0, lx1, ly1;

  // Bresenham working registers
  logic signed [CW-1:0] x, y, err, dx, dy, sx, sy;

  // Sign-extended endpoints
  logic signed [CW-1:0] lx0_e, ly0_e, lx1_e, ly1_e;
  logic signed [CW-1:0] diff_x, diff_y, abs_x, abs_y;

  // Step decision
  logic signed [EW-1:0] e2, dx_e, dy_e;
  logic                 step_x, step_y;
  logic signed [CW-1:0] err_next;
  logic                 at_end;
  logic                 offscreen;
  logic                 advance;

  // Address arithmetic is done modulo 2^ADDR_W; only the low bits survive.
  logic [ADDR_W-1:0] x_w, y_w;

  assign lx0_e = {{2{lx0[WIDTH-1]}}, lx0};
  assign ly0_e = {{2{ly0[WIDTH-1]}}, ly0};
  assign lx1_e = {{2{lx1[WIDTH-1]}}, lx1};
  assign ly1_e = {{2{ly1[WIDTH-1]}}, ly1};

  assign diff_x = lx1_e - lx0_e;
  assign diff_y = ly1_e - ly0_e;
  assign abs_x  = diff_x[CW-1] ? -diff_x : diff_x;
  assign abs_y  = diff_y[CW-1] ? -diff_y : diff_y;

  assign e2     = $signed({err, 1'b0});
  assign dx_e   = $signed({dx[CW-1], dx});
  assign dy_e   = $signed({dy[CW-1], dy});
  // Both tests use the same (old) e2; the two adjustments accumulate.
  assign step_x = (e2 >= dy_e);
  assign step_y = (e2 <= dx_e);
  assign err_next = err + (step_x ? dy : '0) + (step_y ? dx : '0);

  assign at_end = (x == lx1_e) && (y == ly1_e);

`ifdef LINE_CLIP_EN
  localparam logic signed [CW-1:0] SW_C = CW'(SCREEN_W);
  localparam logic signed [CW-1:0] SH_C = CW'(SCREEN_H);
  assign offscreen = (x < 0) || (x >= SW_C) || (y < 0) || (y >= SH_C);
`else
  assign offscreen = 1'b0;
`endif

  assign x_w     = ADDR_W'(x);
  assign y_w     = ADDR_W'(y);
  assign FB_addr = ADDR_W'(y_w * ADDR_W'(SCREEN_W)) + x_w;

  // --------------------------------------------------------------------------
  // FSM state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // --------------------------------------------------------------------------
  // FSM next-state and outputs
  // --------------------------------------------------------------------------
  always_comb begin
    state_next = state;
    FB_WE      = 1'b0;
    sys_finish = 1'b0;
    advance    = 1'b0;
    busy       = (state != S_IDLE);
    case (state)
      S_IDLE: begin
        if (start) begin
          state_next = S_SETUP;
        end
      end
      S_SETUP: begin
        state_next = S_DRAW;
      end
      S_DRAW: begin
        FB_WE = ~offscreen;
        // Off-screen pixels are skipped without waiting for the framebuffer.
        advance = offscreen | FB_ready;
        if (advance && at_end) begin
          state_next = S_DONE;
        end
      end
      S_DONE: begin
        sys_finish = 1'b1;
        state_next = S_IDLE;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Datapath
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      lx0         <= '0;
      ly0         <= '0;
      lx1         <= '0;
      ly1         <= '0;
      x           <= '0;
      y           <= '0;
      err         <= '0;
      dx          <= '0;
      dy          <= '0;
      sx          <= '0;
      sy          <= '0;
      red_out     <= '0;
      green_out   <= '0;
      blue_out    <= '0;
      pixel_count <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            lx0         <= $signed(x0);
            ly0         <= $signed(y0);
            lx1         <= $signed(x1);
            ly1         <= $signed(y1);
            red_out     <= red_in;
            green_out   <= green_in;
            blue_out    <= blue_in;
            pixel_count <= '0;
          end
        end
        S_SETUP: begin
          dx  <= abs_x;
          dy  <= -abs_y;
          sx  <= (lx0_e < lx1_e) ? CW'(1) : -CW'(1);
          sy  <= (ly0_e < ly1_e) ? CW'(1) : -CW'(1);
          err <= abs_x - abs_y;
          x   <= lx0_e;
          y   <= ly0_e;
        end
        S_DRAW: begin
          if (advance) begin
            if (FB_WE) begin
              pixel_count <= pixel_count + 1'b1;
            end
            if (!at_end) begin
              err <= err_next;
              if (step_x) begin
                x <= x + sx;
              end
              if (step_y) begin
                y <= y + sy;
              end
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_line_raster.sv
// ============================================================================
//  Module      : tb_line_raster
//  Description : Scoreboard bench for line_raster. Stimulus pushes the expected
//                pixel stream (from an integer Bresenham reference) and the
//                expected per-line pixel count; a negedge monitor pops and
//                compares on every accepted write and on every finish pulse.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_line_raster;

  localparam int WIDTH = 13;
  localparam int SW    = 320;
  localparam int SH    = 240;
  localparam int AW    = 17;
  localparam int CWD   = 1;

  logic             clk = 1'b0;
  logic             reset;
  logic             start;
  logic [WIDTH-1:0] x0, y0, x1, y1;
  logic [CWD-1:0]   red_in, green_in, blue_in;
  logic             fb_ready;
  logic             fb_we;
  logic [AW-1:0]    fb_addr;
  logic [CWD-1:0]   red_out, green_out, blue_out;
  logic             busy;
  logic             sys_finish;
  logic [AW:0]      pixel_count;

  line_raster #(
    .WIDTH(WIDTH), .SCREEN_W(SW), .SCREEN_H(SH), .ADDR_W(AW), .COLOR_W(CWD)
  ) dut (
    .clk(clk), .reset(reset), .start(start),
    .x0(x0), .y0(y0), .x1(x1), .y1(y1),
    .red_in(red_in), .green_in(green_in), .blue_in(blue_in),
    .FB_ready(fb_ready), .FB_WE(fb_we), .FB_addr(fb_addr),
    .red_out(red_out), .green_out(green_out), .blue_out(blue_out),
    .busy(busy), .sys_finish(sys_finish), .pixel_count(pixel_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    int addr;
    int r;
    int g;
    int b;
  } pix_t;

  pix_t exp_pix[$];
  int   exp_cnt[$];
  int   n_checks = 0;
  int   n_fail   = 0;

`ifdef LINE_CLIP_EN
  localparam bit CLIP = 1'b1;
`else
  localparam bit CLIP = 1'b0;
`endif

  task automatic check(input string name, input int actual, input int expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  // Integer reference: walks the line, queues every visible pixel and the count.
  task automatic model_line(input int ax0, input int ay0, input int ax1, input int ay1,
                            input int r, input int g, input int b,
                            output int total);
    int dx, dy, sx, sy, err, e2, x, y, written;
    pix_t p;
    dx = (ax1 > ax0) ? ax1 - ax0 : ax0 - ax1;
    dy = -((ay1 > ay0) ? ay1 - ay0 : ay0 - ay1);
    sx = (ax0 < ax1) ? 1 : -1;
    sy = (ay0 < ay1) ? 1 : -1;
    err = dx + dy;
    x = ax0;
    y = ay0;
    total = 0;
    written = 0;
    for (int guard = 0; guard < 20000; guard++) begin
      total++;
      if (!CLIP || (x >= 0 && x < SW && y >= 0 && y < SH)) begin
        p.addr = (y * SW + x) & ((1 << AW) - 1);
        p.r = r; p.g = g; p.b = b;
        exp_pix.push_back(p);
        written++;
      end
      if (x == ax1 && y == ay1) break;
      e2 = 2 * err;
      if (e2 >= dy) begin err += dy; x += sx; end
      if (e2 <= dx) begin err += dx; y += sy; end
    end
    exp_cnt.push_back(written);
  endtask

  // ---------------------------------------------------------------- monitor
  logic    prev_stall = 1'b0;
  logic    prev_fin   = 1'b0;
  logic [AW-1:0] prev_addr = '0;

  always @(negedge clk) begin
    pix_t p;
    if (reset) begin
      prev_stall = 1'b0;
      prev_fin   = 1'b0;
    end else begin
      if (prev_stall) begin
        check("stall_hold_we", int'(fb_we), 1);
        check("stall_hold_addr", int'(fb_addr), int'(prev_addr));
      end
      if (fb_we) check("busy_while_writing", int'(busy), 1);
      if (fb_we && fb_ready) begin
        if (exp_pix.size() == 0) begin
          check("unexpected_write_addr", int'(fb_addr), -1);
        end else begin
          p = exp_pix.pop_front();
          check("fb_addr", int'(fb_addr), p.addr);
          check("red_out", int'(red_out), p.r);
          check("green_out", int'(green_out), p.g);
          check("blue_out", int'(blue_out), p.b);
        end
      end
      if (sys_finish) begin
        if (prev_fin) check("finish_single_cycle", 1, 0);
        check("finish_busy", int'(busy), 1);
        check("finish_we", int'(fb_we), 0);
        check("finish_pixels_left", exp_pix.size(), 0);
        if (exp_cnt.size() == 0) begin
          check("unexpected_finish", int'(pixel_count), -1);
        end else begin
          check("pixel_count", int'(pixel_count), exp_cnt.pop_front());
        end
      end
      prev_stall = fb_we && !fb_ready;
      prev_addr  = fb_addr;
      prev_fin   = sys_finish;
    end
  end

  // ---------------------------------------------------------------- driver
  function automatic logic ready_for(input int mode, input int c);
    case (mode)
      1:       return ($urandom_range(0, 3) != 0);
      2:       return !(c >= 3 && c <= 5);
      default: return 1'b1;
    endcase
  endfunction

  // Cycle 0 is the cycle in which start is high; returns the cycle of sys_finish.
  task automatic run_line(input int ax0, input int ay0, input int ax1, input int ay1,
                          input int r, input int g, input int b, input int mode,
                          output int fin, output int total);
    int c;
    model_line(ax0, ay0, ax1, ay1, r, g, b, total);
    @(posedge clk); #1;
    x0 = ax0[WIDTH-1:0]; y0 = ay0[WIDTH-1:0];
    x1 = ax1[WIDTH-1:0]; y1 = ay1[WIDTH-1:0];
    red_in = r[CWD-1:0]; green_in = g[CWD-1:0]; blue_in = b[CWD-1:0];
    start = 1'b1;
    fb_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    c = 1;
    while (c < 6000 && !sys_finish) begin
      fb_ready = ready_for(mode, c);
      if (mode == 2 && c == 4) begin
        // Spurious start mid-line with different endpoints and colour.
        start = 1'b1;
        x1 = 13'd50; y1 = 13'd7;
        red_in = ~red_in;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      c++;
    end
    start = 1'b0;
    fb_ready = 1'b1;
    if (c >= 6000) check("finish_timeout", c, -1);
    fin = c;
    @(posedge clk); #1;
    check("idle_busy", int'(busy), 0);
    check("hold_red", int'(red_out), r);
    check("hold_green", int'(green_out), g);
    check("hold_blue", int'(blue_out), b);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time %0t exceeded limit", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int fin, total, lo, hi, ax0, ay0, ax1, ay1;
    reset = 1'b1; start = 1'b0; fb_ready = 1'b1;
    x0 = '0; y0 = '0; x1 = '0; y1 = '0;
    red_in = '0; green_in = '0; blue_in = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_we", int'(fb_we), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_finish", int'(sys_finish), 0);
    check("rst_count", int'(pixel_count), 0);
    check("rst_addr", int'(fb_addr), 0);
    check("rst_colour", int'({red_out, green_out, blue_out}), 0);
    reset = 1'b0;

    // Directed lines
    run_line(0, 0, 3, 0, 1, 0, 1, 0, fin, total);
    check("finish_cycle_h4", fin, 6);
    run_line(0, 0, 2, 4, 0, 1, 1, 0, fin, total);
    check("finish_cycle_steep", fin, 7);
    run_line(3, 0, 0, 0, 1, 1, 0, 0, fin, total);
    check("finish_cycle_rev", fin, 6);
    run_line(5, 5, 5, 5, 1, 1, 1, 0, fin, total);
    check("finish_cycle_point", fin, 3);
    run_line(0, 0, 3, 0, 0, 0, 1, 2, fin, total);
    check("finish_cycle_stall", fin, 9);

    // Reset in the middle of a long line
    model_line(0, 0, 9, 0, 1, 0, 0, total);
    @(posedge clk); #1;
    x0 = '0; y0 = '0; x1 = 13'd9; y1 = '0;
    red_in = 1'b1; green_in = 1'b0; blue_in = 1'b0;
    start = 1'b1; fb_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    check("midreset_we", int'(fb_we), 0);
    check("midreset_busy", int'(busy), 0);
    check("midreset_count", int'(pixel_count), 0);
    reset = 1'b0;
    exp_pix.delete();
    exp_cnt.delete();
    run_line(0, 0, 9, 0, 1, 0, 0, 0, fin, total);
    check("finish_cycle_after_reset", fin, 12);

`ifdef LINE_CLIP_EN
    run_line(-2, 0, 1, 0, 1, 1, 1, 0, fin, total);
    check("finish_cycle_clip", fin, 6);
    lo = -20; hi = 20;
`else
    lo = 0; hi = 0;
`endif

    // Randomized lines, alternating free-running and random backpressure
    for (int i = 0; i < 24; i++) begin
      ax0 = int'($urandom_range(0, SW - 1 + 2 * hi)) + lo;
      ay0 = int'($urandom_range(0, SH - 1 + 2 * hi)) + lo;
      if (i % 3 == 0) begin
        ax1 = int'($urandom_range(0, SW - 1 + 2 * hi)) + lo;
        ay1 = int'($urandom_range(0, SH - 1 + 2 * hi)) + lo;
      end else begin
        ax1 = ax0 + int'($urandom_range(0, 30)) - 15;
        ay1 = ay0 + int'($urandom_range(0, 30)) - 15;
        if (!CLIP) begin
          if (ax1 < 0) ax1 = 0;
          if (ax1 > SW - 1) ax1 = SW - 1;
          if (ay1 < 0) ay1 = 0;
          if (ay1 > SH - 1) ay1 = SH - 1;
        end
      end
      run_line(ax0, ay0, ax1, ay1, int'($urandom_range(0, 1)), int'($urandom_range(0, 1)),
               int'($urandom_range(0, 1)), i % 2, fin, total);
      if (i % 2 == 0) check("finish_cycle_rand", fin, total + 2);
    end

    repeat (3) @(posedge clk);
    #1;
    check("end_pixels_left", exp_pix.size(), 0);
    check("end_counts_left", exp_cnt.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
